// File: rtl/barrel_shift_pkg.sv
// barrel_shift_pkg: shared command types and default widths for the shifter arbiter.
package barrel_shift_pkg;
  localparam int DEF_DATA_W  = 4;
  localparam int DEF_SHAMT_W = 2;
  typedef enum logic {SEL_SHIFT = 1'b0, SEL_ROTATE = 1'b1} sel_e;
  typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} dir_e;
  typedef struct packed {
    sel_e                    select;
    dir_e                    direction;
    logic [DEF_SHAMT_W-1:0]  shift_value;
    logic [DEF_DATA_W-1:0]   din;
  } shift_cmd_t;
endpackage

// File: rtl/barrel_shift_arbiter_rr.sv
// rr_arbiter: round-robin pick of the first request at or after the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx
);
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_en && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_gnt = '0;
        o_gnt[(int'(i_ptr) + k) % NUM_REQ] = 1'b1;
        o_idx = ID_W'((int'(i_ptr) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/barrel_shifter.sv
// barrel_shifter: combinational logical shift / rotate, left or right.
module barrel_shifter #(
  parameter int DATA_W  = 4,
  parameter int SHAMT_W = 2
) (
  input  logic [DATA_W-1:0]  din,
  input  logic [SHAMT_W-1:0] shift_value,
  input  logic               select,
  input  logic               direction,
  output logic [DATA_W-1:0]  dout
);
  logic [2*DATA_W-1:0] w_dd;
  logic [2*DATA_W-1:0] w_rl;
  logic [2*DATA_W-1:0] w_rr;
  logic [DATA_W-1:0]   w_sh;
  assign w_dd = {din, din};
  // Rotation wraps modulo the data width; plain shifts zero-fill.
  assign w_rl = w_dd << (int'(shift_value) % DATA_W);
  assign w_rr = w_dd >> (int'(shift_value) % DATA_W);
  assign w_sh = direction ? din << shift_value : din >> shift_value;
  assign dout = !select ? w_sh : direction ? w_rl[2*DATA_W-1:DATA_W] : w_rr[DATA_W-1:0];
endmodule

// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter: round-robin sharing of one barrel_shifter with a registered response.
// Optional BARREL_ARB_STATS_EN adds saturating per-requester grant counters on grant_cnt.
module barrel_shift_arbiter
  import barrel_shift_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHAMT_W = DEF_SHAMT_W,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_select,
  input  logic [NUM_REQ-1:0]         req_direction,
  input  logic [NUM_REQ*SHAMT_W-1:0] req_shift,
  input  logic [NUM_REQ*DATA_W-1:0]  req_din,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DATA_W-1:0]          rsp_dout
`ifdef BARREL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]      grant_cnt
`endif
);
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [DATA_W-1:0]  r_rsp_dout;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic               w_slot_free;
  sel_e               w_sel;
  dir_e               w_dir;
  logic [DATA_W-1:0]  w_dout;
  // Gating with rst_n keeps req_ready low for the whole reset window.
  assign w_slot_free = rst_n && (!r_rsp_valid || rsp_ready);
  assign w_any       = |w_gnt;
  assign req_ready   = w_gnt;
  assign w_sel       = sel_e'(req_select[w_idx]);
  assign w_dir       = dir_e'(req_direction[w_idx]);
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .i_en  (w_slot_free),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );
  barrel_shifter #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_shifter (
    .din         (req_din[w_idx*DATA_W +: DATA_W]),
    .shift_value (req_shift[w_idx*SHAMT_W +: SHAMT_W]),
    .select      (w_sel == SEL_ROTATE),
    .direction   (w_dir == DIR_LEFT),
    .dout        (w_dout)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_dout  <= '0;
      r_rr_ptr    <= '0;
    end else if (w_any) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_idx;
      r_rsp_dout  <= w_dout;
      r_rr_ptr    <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + ID_W'(1);
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_dout  = r_rsp_dout;
`ifdef BARREL_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    logic [15:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else if (w_gnt[g] && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
    assign grant_cnt[g*16 +: 16] = r_cnt;
  end
`endif
endmodule
